// File: rtl/scan_raycast_scheduler.sv
// Scan ray-cast scheduler: walks one stored lidar scan beam by beam, skips empty
// returns and hands each valid beam to a ray tracer, one ray in flight at a time.
module scan_raycast_scheduler #(
    parameter int NUM_BEAMS  = 360,
    parameter int BEAM_IDX_W = $clog2(NUM_BEAMS),
    parameter int FIXED_W    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_scan_start,
    input  logic                  i_abort,
    input  logic [FIXED_W-1:0]    i_pose_x,
    input  logic [FIXED_W-1:0]    i_pose_y,
    input  logic [FIXED_W-1:0]    i_pose_theta,
    input  logic [FIXED_W-1:0]    i_max_range,
    output logic [BEAM_IDX_W-1:0] o_beam_addr,
    input  logic [FIXED_W-1:0]    i_beam_range,
    input  logic [FIXED_W-1:0]    i_beam_angle,
    output logic                  o_bres_start,
    output logic [FIXED_W-1:0]    o_bres_magnitude,
    output logic [FIXED_W-1:0]    o_bres_angle,
    output logic [FIXED_W-1:0]    o_bres_sensor_x,
    output logic [FIXED_W-1:0]    o_bres_sensor_y,
    input  logic                  i_bres_busy,
    output logic                  o_busy,
    output logic                  o_scan_done,
    output logic [BEAM_IDX_W:0]   o_beams_traced,
    output logic [BEAM_IDX_W:0]   o_beams_skipped
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_LAUNCH, S_GUARD, S_RUN, S_FINISH
    } state_t;

    localparam logic [BEAM_IDX_W-1:0] IDX_LAST = BEAM_IDX_W'(NUM_BEAMS - 1);
    localparam logic [BEAM_IDX_W-1:0] IDX_ONE  = BEAM_IDX_W'(1);
    localparam logic [BEAM_IDX_W:0]   CNT_ONE  = (BEAM_IDX_W+1)'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [BEAM_IDX_W-1:0] r_index;
    logic [BEAM_IDX_W:0]   r_traced;
    logic [BEAM_IDX_W:0]   r_skipped;
    logic                  r_abort_flag;
    logic [FIXED_W-1:0]    r_pose_x, r_pose_y, r_pose_theta, r_max_range;
    logic [FIXED_W-1:0]    r_magnitude, r_angle, r_sensor_x, r_sensor_y;

    logic                  w_accept, w_load_ops, w_skip, w_trace_done, w_inc_index, w_set_abort;
    logic                  w_last;
    logic [FIXED_W-1:0]    w_clamped;

    assign w_last    = (r_index == IDX_LAST);
    assign w_clamped = ($signed(i_beam_range) < $signed(r_max_range)) ? i_beam_range : r_max_range;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load_ops   = 1'b0;
        w_skip       = 1'b0;
        w_trace_done = 1'b0;
        w_inc_index  = 1'b0;
        w_set_abort  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_scan_start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: w_next_state = i_abort ? S_FINISH : S_LOAD;
            S_LOAD: begin
                if (i_abort) begin
                    w_next_state = S_FINISH;
                end else if (i_beam_range == '0) begin
                    w_skip = 1'b1;
                    if (w_last) begin
                        w_next_state = S_FINISH;
                    end else begin
                        w_inc_index  = 1'b1;
                        w_next_state = S_FETCH;
                    end
                end else begin
                    w_load_ops   = 1'b1;
                    w_next_state = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_set_abort  = i_abort;
                w_next_state = S_GUARD;
            end
            // The tracer raises busy one cycle after the start pulse, so it is not trusted here.
            S_GUARD: begin
                w_set_abort  = i_abort;
                w_next_state = S_RUN;
            end
            S_RUN: begin
                w_set_abort = i_abort;
                if (!i_bres_busy) begin
                    w_trace_done = 1'b1;
                    if (i_abort || r_abort_flag || w_last) begin
                        w_next_state = S_FINISH;
                    end else begin
                        w_inc_index  = 1'b1;
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_index      <= '0;
            r_traced     <= '0;
            r_skipped    <= '0;
            r_abort_flag <= 1'b0;
            r_pose_x     <= '0;
            r_pose_y     <= '0;
            r_pose_theta <= '0;
            r_max_range  <= '0;
            r_magnitude  <= '0;
            r_angle      <= '0;
            r_sensor_x   <= '0;
            r_sensor_y   <= '0;
        end else begin
            if (w_accept) begin
                r_pose_x     <= i_pose_x;
                r_pose_y     <= i_pose_y;
                r_pose_theta <= i_pose_theta;
                r_max_range  <= i_max_range;
                r_index      <= '0;
                r_traced     <= '0;
                r_skipped    <= '0;
                r_abort_flag <= 1'b0;
            end
            if (w_inc_index)  r_index   <= r_index + IDX_ONE;
            if (w_skip)       r_skipped <= r_skipped + CNT_ONE;
            if (w_trace_done) r_traced  <= r_traced + CNT_ONE;
            if (w_set_abort)               r_abort_flag <= 1'b1;
            else if (r_state == S_FINISH)  r_abort_flag <= 1'b0;
            // Heading sum wraps modulo 2^FIXED_W on purpose: angles are circular.
            if (w_load_ops) begin
                r_magnitude <= w_clamped;
                r_angle     <= i_beam_angle + r_pose_theta;
                r_sensor_x  <= r_pose_x;
                r_sensor_y  <= r_pose_y;
            end
        end
    end

    assign o_beam_addr      = r_index;
    assign o_bres_start     = (r_state == S_LAUNCH);
    assign o_bres_magnitude = r_magnitude;
    assign o_bres_angle     = r_angle;
    assign o_bres_sensor_x  = r_sensor_x;
    assign o_bres_sensor_y  = r_sensor_y;
    assign o_busy           = (r_state != S_IDLE);
    assign o_scan_done      = (r_state == S_FINISH);
    assign o_beams_traced   = r_traced;
    assign o_beams_skipped  = r_skipped;

endmodule

// File: doc/scan_raycast_scheduler.md
SCAN_RAYCAST_SCHEDULER -- requirements
Module: scan_raycast_scheduler

Interface
REQ-001 SHALL have parameter NUM_BEAMS, default 360, beams per scan.
REQ-002 SHALL have parameter BEAM_IDX_W, default $clog2(NUM_BEAMS), beam index width.
REQ-003 SHALL have port clock, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port scan_start, input, 1, single-cycle request to trace one stored scan.
REQ-006 SHALL have port abort, input, 1, cancel the scan in progress.
REQ-007 SHALL have ports pose_x, pose_y, input, fixed_t, sensor position; pose_theta, input, fixed_t, sensor heading.
REQ-008 SHALL have port max_range, input, fixed_t, range clamp.
REQ-009 SHALL have port beam_addr, output, BEAM_IDX_W, scan RAM read address.
REQ-010 SHALL have port beam_range, input, fixed_t, scan RAM data; valid exactly 1 cycle after beam_addr.
REQ-011 SHALL have port beam_angle, input, fixed_t, beam angle relative to heading; same timing as beam_range.
REQ-012 SHALL have port bres_start, output, 1, start pulse to the ray tracer.
REQ-013 SHALL have ports bres_magnitude, bres_angle, bres_sensor_x, bres_sensor_y, output, fixed_t, tracer operands.
REQ-014 SHALL have port bres_busy, input, 1, ray tracer busy.
REQ-015 SHALL have port busy, output, 1, scan in progress.
REQ-016 SHALL have port scan_done, output, 1, single-cycle pulse at scan completion or abort.
REQ-017 SHALL have ports beams_traced and beams_skipped, output, BEAM_IDX_W+1, per-scan counters.

Function
REQ-018 SHALL implement states IDLE, FETCH, LOAD, LAUNCH, GUARD, RUN, FINISH.
REQ-019 IDLE: on scan_start, SHALL latch pose_x, pose_y, pose_theta and max_range; clear index and both counters; go to FETCH.
REQ-020 FETCH: SHALL drive beam_addr = index; go to LOAD next cycle.
REQ-021 LOAD: SHALL skip the beam if beam_range == 0 by incrementing beams_skipped and going to the next-beam step; otherwise go to LAUNCH.
REQ-022 LOAD: SHALL register bres_magnitude = min(beam_range, latched max_range) using signed fixed_t compare.
REQ-023 LOAD: SHALL register bres_angle = beam_angle + latched pose_theta, wrapped in fixed_t width with no saturation.
REQ-024 LOAD: SHALL register bres_sensor_x and bres_sensor_y from the latched pose.
REQ-025 LAUNCH: SHALL assert bres_start for exactly 1 cycle with operands already stable; go to GUARD.
REQ-026 GUARD: SHALL ignore bres_busy for 1 cycle; go to RUN.
REQ-027 RUN: SHALL hold while bres_busy = 1; when bres_busy = 0, increment beams_traced and go to the next-beam step.
REQ-028 Next-beam step: if index == NUM_BEAMS-1, SHALL go to FINISH; else increment index and go to FETCH.
REQ-029 FINISH: SHALL pulse scan_done for 1 cycle and return to IDLE.
REQ-030 Operand outputs SHALL hold constant from LAUNCH through RUN exit.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 beams_traced and beams_skipped SHALL hold their final values in IDLE until the next accepted scan_start.
REQ-033 scan_start while busy = 1 SHALL be ignored.
REQ-034 abort in FETCH, LOAD or FINISH SHALL go to FINISH.
REQ-035 abort in LAUNCH, GUARD or RUN SHALL set an abort flag; the tracer SHALL NOT be cut mid-ray; RUN exit then goes to FINISH without incrementing index.
REQ-036 abort in IDLE SHALL have no effect.
REQ-037 Simultaneous scan_start and abort in IDLE: scan_start SHALL win and abort is dropped.
REQ-038 Invariant: beams_traced + beams_skipped SHALL equal NUM_BEAMS at scan_done when no abort occurred.
REQ-039 Per-beam latency SHALL be 2 cycles for a skipped beam (FETCH, LOAD) and 4 + tracer busy cycles for a traced beam.

Reset
REQ-040 On reset = 0, SHALL asynchronously enter IDLE with all outputs, counters, index, latched pose and abort flag 0.
REQ-041 Reset mid-scan SHALL abandon the scan with no scan_done pulse.
REQ-042 Reset SHALL be released synchronously; the first scan_start SHALL be accepted on the first clock edge with reset = 1.

Verification
REQ-043 NUM_BEAMS=4, ranges {2.0,0,3.0,1.0}, max_range 2.5, tracer busy 5 cycles -> 3 bres_start pulses, magnitudes {2.0,2.5,1.0}, traced=3, skipped=1, one scan_done.
REQ-044 pose_theta near +max fixed_t, beam_angle positive -> bres_angle wraps modulo 2^FIXED_WIDTH.
REQ-045 abort during RUN of beam 1 -> tracer completes, no further bres_start, scan_done once, traced=2.
REQ-046 scan_start pulsed during busy -> ignored; counters unaffected.
REQ-047 reset asserted in RUN -> all outputs 0 immediately (asynchronously), no scan_done, new scan works after release.
REQ-048 All ranges 0 -> no bres_start, skipped=NUM_BEAMS, scan_done 2*NUM_BEAMS+1 cycles after scan_start.
